// File: rtl/inverse_sequencer.sv
// inverse_sequencer: control FSM that drives an external 4-bit x/y datapath
// so that y ends up holding the additive inverse (mod 16) of imm.
// Ports: clk, reset (async, active-low), start, zero (x+y==0 flag) in;
//        op_sel, en_x, en_y, y_sel (datapath controls), busy, done,
//        error (timeout, valid with done), steps (y increments) out.
// Optional build macro: INV_TIMEOUT_EN adds a 15-increment timeout.
module inverse_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       zero,
    output logic [1:0] op_sel,
    output logic       en_x,
    output logic       en_y,
    output logic       y_sel,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] steps
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_X,
        CLR_Y,
        CHECK,
        INC_Y,
        DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] steps_q, steps_d;

`ifdef INV_TIMEOUT_EN
    // Set only on the CHECK->DONE timeout transition, so it is high
    // exactly during the DONE cycle of a timed-out operation.
    logic timeout_q, timeout_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            steps_q <= 4'd0;
        end else begin
            state_q <= state_d;
            steps_q <= steps_d;
        end
    end

`ifdef INV_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        steps_d = steps_q;
        op_sel  = 2'b00;
        en_x    = 1'b0;
        en_y    = 1'b0;
        y_sel   = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
`ifdef INV_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = LOAD_X;
                    steps_d = 4'd0;
                end
            end
            LOAD_X: begin
                en_x    = 1'b1;
                state_d = CLR_Y;
            end
            CLR_Y: begin
                y_sel   = 1'b1;
                en_y    = 1'b1;
                state_d = CHECK;
            end
            CHECK: begin
                if (zero) begin
                    state_d = DONE;
`ifdef INV_TIMEOUT_EN
                end else if (steps_q == 4'd15) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
`endif
                end else begin
                    state_d = INC_Y;
                end
            end
            INC_Y: begin
                op_sel  = 2'b01;
                en_y    = 1'b1;
                steps_d = steps_q + 4'd1;
                state_d = CHECK;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef INV_TIMEOUT_EN
    assign error = timeout_q;
`else
    assign error = 1'b0;
`endif

    assign steps = steps_q;

endmodule
